// File: rtl/stopwatch_btn_ctrl.sv
// stopwatch_btn_ctrl
//
// Input-conditioning stage in front of the stopwatch/clock core. Each raw
// button and switch is synchronised with two flops and debounced. The
// debounced buttons drive a two-state PAUSED/RUNNING machine. The machine
// produces a start/stop level and one-cycle reset/set request pulses. The
// debounced switches are re-registered and passed straight through.
//
// Optional feature, macro BTN_LONGPRESS_EN:
//   When defined, start/stop acts on the release of btn_ss. Holding btn_ss for
//   LONG_CYCLES debounced cycles issues a reset0 pulse and forces PAUSED. The
//   release that follows a long press is ignored.
//   When undefined, start/stop acts on the press and LONG_CYCLES is unused.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised samples needed to accept a new
//                    level (>= 1)
//   LONG_CYCLES      long-press hold length (> DEBOUNCE_CYCLES)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous reset, active low
//   btn_ss   in   raw start/stop button (1 = pressed)
//   btn_rst  in   raw reset button (1 = pressed)
//   btn_set  in   raw set button (1 = pressed)
//   sw_mood  in   raw mode switch (0 = stopwatch, 1 = time)
//   sw_ctrl  in   raw direction switch (0 = up, 1 = down)
//   pause1   out  1 = PAUSED, 0 = RUNNING; this is the FSM state register
//   reset0   out  one-cycle reset request
//   set      out  one-cycle load request, only issued while PAUSED
//   mood     out  debounced sw_mood, registered
//   ctrl0    out  debounced sw_ctrl, registered
module stopwatch_btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_ss,
    input  logic btn_rst,
    input  logic btn_set,
    input  logic sw_mood,
    input  logic sw_ctrl,
    output logic pause1,
    output logic reset0,
    output logic set,
    output logic mood,
    output logic ctrl0
);

    localparam int N_IN = 5;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);

    // Bit order: 0 btn_ss, 1 btn_rst, 2 btn_set, 3 sw_mood, 4 sw_ctrl
    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync1;
    logic [N_IN-1:0] sync2;
    logic [N_IN-1:0] stable;
    logic [2:0]      stable_d;   // previous debounced level, buttons only
    logic [CW-1:0]   cnt [N_IN];

    assign raw = {sw_ctrl, sw_mood, btn_set, btn_rst, btn_ss};

    // Marker block that exists only for an illegal parameter combination, so
    // the mistake is visible in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_d <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable[2:0];
        end
    end

    // The counter holds the number of differing samples seen so far. On the
    // sample that would make it DEBOUNCE_CYCLES the level flips instead, so
    // the count never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    logic [2:0] press_ev;
    logic       rst_ev;
    logic       set_ev;
    logic       ss_ev;
    logic       long_ev;

    assign press_ev = stable[2:0] & ~stable_d;
    assign rst_ev   = press_ev[1];
    assign set_ev   = press_ev[2];

`ifdef BTN_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);

    // Counts debounced cycles of btn_ss held high, saturating at LONG_CYCLES.
    // It still holds the full count during the release cycle, so the release
    // can tell a short press from a long one.
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (!stable[0]) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HW'(LONG_CYCLES)) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign long_ev = stable[0] && (hold_cnt == HW'(LONG_CYCLES - 1));
    assign ss_ev   = !stable[0] && stable_d[0] && (hold_cnt < HW'(LONG_CYCLES));
`else
    assign long_ev = 1'b0;
    assign ss_ev   = press_ev[0];
`endif

    typedef enum logic {
        RUNNING = 1'b0,
        PAUSED  = 1'b1
    } state_t;

    state_t state;

    assign pause1 = (state == PAUSED);

    // Reset beats start/stop, and start/stop beats set. Set is judged against
    // the state held before any toggle in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= PAUSED;
            reset0 <= 1'b0;
            set    <= 1'b0;
            mood   <= 1'b0;
            ctrl0  <= 1'b0;
        end else begin
            reset0 <= rst_ev || long_ev;
            set    <= set_ev && (state == PAUSED) && !(rst_ev || long_ev);
            mood   <= stable[3];
            ctrl0  <= stable[4];
            if (rst_ev || long_ev) begin
                state <= PAUSED;
            end else if (ss_ev) begin
                state <= (state == PAUSED) ? RUNNING : PAUSED;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Bench for stopwatch_btn_ctrl (DEBOUNCE_CYCLES = 4, LONG_CYCLES = 16).
// Build with +define+BTN_LONGPRESS_EN to cover the long-press variant.
module tb_stopwatch_btn_ctrl;

    localparam int D = 4;
    localparam int L = 16;
`ifdef BTN_LONGPRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_ss = 1'b0, btn_rst = 1'b0, btn_set = 1'b0;
    logic sw_mood = 1'b0, sw_ctrl = 1'b0;
    logic pause1, reset0, set, mood, ctrl0;

    int checks = 0;
    int errors = 0;

    stopwatch_btn_ctrl #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk(clk), .reset(reset),
        .btn_ss(btn_ss), .btn_rst(btn_rst), .btn_set(btn_set),
        .sw_mood(sw_mood), .sw_ctrl(sw_ctrl),
        .pause1(pause1), .reset0(reset0), .set(set),
        .mood(mood), .ctrl0(ctrl0)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A debounced level flips once the last D synchronised samples all differ
    // from it; the synchronised sample at an edge is the raw value two edges
    // earlier. Outputs react one edge after the debounced level moves.
    logic [4:0] raw_hist[$];
    logic [4:0] syn_hist[$];
    logic [4:0] deb = '0;
    logic [4:0] deb_prev = '0;
    int  hold_len = 0;
    bit  m_paused = 1'b1;
    bit  m_reset0 = 1'b0, m_set = 1'b0, m_mood = 1'b0, m_ctrl = 1'b0;
    logic [4:0] exp_q[$];   // {pause1, reset0, set, mood, ctrl0}

    task automatic model_step();
        logic [4:0] rise;
        logic [4:0] synced;
        bit rq, tog, all_diff;
        rise = deb & ~deb_prev;
        tog = 1'b0;
        rq = rise[1];
`ifdef BTN_LONGPRESS_EN
        if (deb[0]) begin
            hold_len++;
            if (hold_len == L) rq = 1'b1;
        end else begin
            if (deb_prev[0] && hold_len < L) tog = 1'b1;
            hold_len = 0;
        end
`else
        tog = rise[0];
`endif
        m_set    = rise[2] && m_paused && !rq;
        m_reset0 = rq;
        if (rq) m_paused = 1'b1;
        else if (tog) m_paused = !m_paused;
        m_mood = deb[3];
        m_ctrl = deb[4];

        deb_prev = deb;
        synced = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 5'b0;
        syn_hist.push_back(synced);
        if (syn_hist.size() > D) void'(syn_hist.pop_front());
        if (syn_hist.size() == D) begin
            for (int i = 0; i < 5; i++) begin
                all_diff = 1'b1;
                foreach (syn_hist[j]) if (syn_hist[j][i] == deb[i]) all_diff = 1'b0;
                if (all_diff) deb[i] = ~deb[i];
            end
        end
        raw_hist.push_back({sw_ctrl, sw_mood, btn_set, btn_rst, btn_ss});
        if (raw_hist.size() > 4) void'(raw_hist.pop_front());
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            raw_hist.delete();
            syn_hist.delete();
            deb = '0; deb_prev = '0; hold_len = 0;
            m_paused = 1'b1; m_reset0 = 1'b0; m_set = 1'b0; m_mood = 1'b0; m_ctrl = 1'b0;
        end else begin
            model_step();
        end
        exp_q.push_back({m_paused, m_reset0, m_set, m_mood, m_ctrl});
    end

    // ---------------- scoreboard compare ----------------
    int r0_cnt = 0;
    int set_cnt = 0;

    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        r0_cnt  += int'(reset0);
        set_cnt += int'(set);
        if (exp_q.size() == 0) begin
            check_int("exp_q_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_bit("cyc_pause1", pause1, e[4]);
            check_bit("cyc_reset0", reset0, e[3]);
            check_bit("cyc_set",    set,    e[2]);
            check_bit("cyc_mood",   mood,   e[1]);
            check_bit("cyc_ctrl0",  ctrl0,  e[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        @(negedge clk);
        r0_cnt = 0;
        set_cnt = 0;
    endtask

    // Hold the selected buttons for 'hold' sampled cycles, release, then settle.
    task automatic press(input logic ss, input logic rs, input logic st,
                         input int hold, input int settle);
        @(negedge clk);
        btn_ss = ss; btn_rst = rs; btn_set = st;
        wait_neg(hold);
        btn_ss = 1'b0; btn_rst = 1'b0; btn_set = 1'b0;
        wait_neg(settle);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        wait_neg(3);
        check_bit("rst_pause1", pause1, 1'b1);
        check_bit("rst_reset0", reset0, 1'b0);
        check_bit("rst_set",    set,    1'b0);
        check_bit("rst_mood",   mood,   1'b0);
        check_bit("rst_ctrl0",  ctrl0,  1'b0);
        reset = 1'b1;

        // Start/stop held 10 cycles: press effect lands at edge 6.
        clear_counts();
        btn_ss = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_bit("ss_edge5", pause1, 1'b1);
        @(posedge clk);
        #1 check_bit("ss_edge6", pause1, LP ? 1'b1 : 1'b0);
        wait_neg(4);
        btn_ss = 1'b0;
        wait_neg(12);
        check_bit("ss_running", pause1, 1'b0);
        check_int("ss_no_reset0", r0_cnt, 0);
        check_int("ss_no_set", set_cnt, 0);

        // Short reset glitch is filtered; a 5-cycle one pulses once.
        clear_counts();
        press(1'b0, 1'b1, 1'b0, 3, 12);
        check_int("rst_glitch_pulses", r0_cnt, 0);
        check_bit("rst_glitch_running", pause1, 1'b0);
        clear_counts();
        press(1'b0, 1'b1, 1'b0, 5, 12);
        check_int("rst5_pulses", r0_cnt, 1);
        check_bit("rst5_paused", pause1, 1'b1);

        // Start/stop glitch gives no toggle.
        press(1'b1, 1'b0, 1'b0, 3, 12);
        check_bit("ss_glitch_paused", pause1, 1'b1);

        // Set ignored while running, honoured while paused.
        press(1'b1, 1'b0, 1'b0, 6, 12);
        check_bit("run_again", pause1, 1'b0);
        clear_counts();
        press(1'b0, 1'b0, 1'b1, 6, 12);
        check_int("set_when_running", set_cnt, 0);
        press(1'b1, 1'b0, 1'b0, 6, 12);
        check_bit("stopped", pause1, 1'b1);
        clear_counts();
        press(1'b0, 1'b0, 1'b1, 6, 12);
        check_int("set_when_paused", set_cnt, 1);
        check_int("set_no_reset0", r0_cnt, 0);

        // Start/stop with set while paused: set uses the pre-toggle state.
        clear_counts();
        press(1'b1, 1'b0, 1'b1, 6, 12);
        check_int("ss_set_pulses", set_cnt, 1);
        check_bit("ss_set_running", pause1, 1'b0);

        // Start/stop with reset while running: reset wins.
        clear_counts();
        press(1'b1, 1'b1, 1'b0, 6, 12);
        check_int("ss_rst_pulses", r0_cnt, 1);
        check_bit("ss_rst_state", pause1, LP ? 1'b0 : 1'b1);
        wait_neg(10);
        check_bit("ss_rst_state_later", pause1, LP ? 1'b0 : 1'b1);

        // Reset with set while paused: set suppressed.
        press(1'b0, 1'b1, 1'b0, 6, 12);
        clear_counts();
        press(1'b0, 1'b1, 1'b1, 6, 12);
        check_int("rst_set_reset0", r0_cnt, 1);
        check_int("rst_set_set", set_cnt, 0);
        check_bit("rst_set_paused", pause1, 1'b1);

`ifdef BTN_LONGPRESS_EN
        // Short hold toggles only on release; long hold resets and pauses.
        @(negedge clk);
        btn_ss = 1'b1;
        wait_neg(8);
        check_bit("lp_short_before_release", pause1, 1'b1);
        btn_ss = 1'b0;
        wait_neg(12);
        check_bit("lp_short_after_release", pause1, 1'b0);
        clear_counts();
        press(1'b1, 1'b0, 1'b0, 30, 14);
        check_int("lp_long_pulses", r0_cnt, 1);
        check_bit("lp_long_paused", pause1, 1'b1);
`endif

        // Mode switch: glitch ignored, steady change passes through.
        @(negedge clk);
        sw_mood = 1'b1;
        wait_neg(2);
        sw_mood = 1'b0;
        wait_neg(10);
        check_bit("mood_glitch", mood, 1'b0);
        sw_mood = 1'b1;
        wait_neg(10);
        check_bit("mood_high", mood, 1'b1);

        // Reset mid-debounce discards the count; re-debounced after release.
        @(negedge clk);
        sw_ctrl = 1'b1;
        wait_neg(3);
        reset = 1'b0;
        #1 check_bit("ctrl_in_reset", ctrl0, 1'b0);
        check_bit("mood_in_reset", mood, 1'b0);
        wait_neg(2);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_bit("ctrl_edge5", ctrl0, 1'b0);
        @(posedge clk);
        #1 check_bit("ctrl_edge6", ctrl0, 1'b1);
        check_bit("ctrl_pause1_after_reset", pause1, 1'b1);

        wait_neg(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_btn_ctrl.md
# stopwatch_btn_ctrl

Input-conditioning stage directly upstream of the stopwatch/clock core. It synchronises and debounces the raw push-buttons and slide switches, and converts them into the core's control inputs: a start/stop level `pause1`, single-cycle `reset0` and `set` pulses, and clean `mood` and `ctrl0` levels. All outputs are registered.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive cycles a synchronised input must hold a new value before the debounced level changes (≥1).
- `LONG_CYCLES`, default 16: hold length that qualifies as a long press (used only with `BTN_LONGPRESS_EN`; must be > `DEBOUNCE_CYCLES`).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  raw start/stop button, 1 = pressed.
- `btn_rst`  in  1  raw reset button, 1 = pressed.
- `btn_set`  in  1  raw set button, 1 = pressed.
- `sw_mood`  in  1  raw mode switch: 0 = stopwatch, 1 = time.
- `sw_ctrl`  in  1  raw direction switch: 0 = count up, 1 = count down.
- `pause1`  out  1  level: 1 = paused, 0 = running.
- `reset0`  out  1  one-cycle reset request pulse.
- `set`  out  1  one-cycle load request pulse.
- `mood`  out  1  debounced `sw_mood`.
- `ctrl0`  out  1  debounced `sw_ctrl`.

## Operation
- **Input conditioning.** Every raw input passes through a 2-flop synchroniser and then its own debouncer.
  - The debouncer counter clears whenever the synchronised value equals the stable value.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, the stable value takes the synchronised value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter never wraps.
- **Press events.** A press event is a 0→1 transition of a debounced button. A release event is a 1→0 transition. Each event lasts exactly one cycle.
- **FSM.** States are `PAUSED` (`pause1`=1) and `RUNNING` (`pause1`=0). Reset enters `PAUSED`.
  - Start/stop event: `PAUSED`↔`RUNNING`.
  - `btn_rst` press: `reset0` pulses and the FSM enters `PAUSED` from either state.
  - `btn_set` press: `set` pulses only in `PAUSED`. In `RUNNING` it is ignored; it is not queued.
- **Priority within one cycle.** Reset > start/stop > set.
  - Reset together with start/stop: result is `PAUSED`, with no toggle.
  - Reset together with set: `set` is suppressed.
  - Start/stop together with set: `set` is evaluated against the pre-transition state.
- **Switches.** `mood` and `ctrl0` are the debounced switch levels, registered. They are independent of the FSM.

## Timing
- **Reset values.** `pause1`=1, `reset0`=0, `set`=0, `mood`=0, `ctrl0`=0. All synchronisers, debouncers and counters are zero.
- **Latency.** A raw input first sampled high at edge 0 and held updates the debounced level at edge 1+`DEBOUNCE_CYCLES`. The output effect (pulse or `pause1` change) is visible after edge 2+`DEBOUNCE_CYCLES`. Releases take the same latency.
- **Glitches.** A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.
- **Pulse spacing.** Holding a button generates exactly one press event. Consecutive pulses on `reset0` or `set` are separated by at least 2·`DEBOUNCE_CYCLES` cycles.
- **Reset during operation.** Asserting `reset` during a debounce or long-press count discards it. After deassertion, a button still held is seen as a new press once debounced.

## Configuration
- **`BTN_LONGPRESS_EN` defined:**
  - Start/stop toggles on the release event, not the press, and only if the debounced hold lasted fewer than `LONG_CYCLES` cycles.
  - A hold counter runs while debounced `btn_ss`=1. It saturates at `LONG_CYCLES`.
  - When the hold counter reaches `LONG_CYCLES`, one `reset0` pulse is issued and the FSM is forced to `PAUSED`.
  - The following release is then ignored.
  - A long press and a `btn_rst` press in the same cycle produce a single `reset0` pulse.
- **`BTN_LONGPRESS_EN` undefined:** start/stop toggles on the press event. There is no hold counter, and `LONG_CYCLES` is unused.

## Test plan
With `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=16:
1. After reset, hold `btn_ss` high for 10 cycles (macro off) → `pause1` falls 6 cycles after the first sample and stays 0; `reset0`=`set`=0 throughout.
2. 3-cycle pulse on `btn_rst` → no `reset0` pulse; a 5-cycle pulse → exactly one `reset0` cycle and `pause1`=1.
3. While `RUNNING`, press `btn_set` → `set` stays 0. Stop, then press `btn_set` → one `set` pulse.
4. `btn_ss` and `btn_rst` rise on the same cycle while `RUNNING` → one `reset0` pulse; `pause1`=1 and stays 1.
5. Macro on: hold `btn_ss` 8 cycles then release → `pause1` toggles after the release. Hold 30 cycles → one `reset0` pulse at hold count 16; `pause1`=1 and does not change on release.
6. Toggle `sw_ctrl` high, then assert `reset` (low) mid-debounce → `ctrl0`=0. Release `reset` with `sw_ctrl` still high → `ctrl0`=1 at 6 cycles.
